// File: rtl/oserdes_burst_gearbox_if.sv
// oserdes_burst_gearbox_if
// Input word handshake for oserdes_burst_gearbox.
//   in_data   word, one W-bit field per channel
//   in_valid  in_data is valid
//   in_ready  gearbox FIFO can take a word this cycle
// master: word producer. slave: the gearbox.
interface oserdes_burst_gearbox_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/oserdes_burst_gearbox.sv
// oserdes_burst_gearbox
// Fabric-side front end for a bank of output serializers. Buffers wide per-channel words in a
// small FIFO and streams one SER_WIDTH-bit slice per lane per cycle, framed as
// preamble / back-to-back data / postamble, with a shared tristate control.
// Ports:
//   c       divided serializer clock, rising edge
//   r       asynchronous active-high reset
//   in_if   word handshake (slave modport): in_data, in_valid, in_ready
//   dout    per-lane slice, lane ch at [ch*SER_WIDTH +: SER_WIDTH], bit 0 first out
//   tout    tristate control to all T inputs, 1 = high-Z
//   busy    framer is not idle
//   bursts  burst counter (16-bit, wrapping)
// Build option: define OSERDES_BURST_GEARBOX_STATS_EN to count bursts; otherwise bursts is 0.
module oserdes_burst_gearbox #(
    parameter int unsigned CHANNELS  = 1,
    parameter int unsigned SER_WIDTH = 4,
    parameter int unsigned RATIO     = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PRE_LEN   = 1,
    parameter int unsigned POST_LEN  = 1,
    parameter logic        IDLE_VAL  = 1'b1
) (
    input  logic                          c,
    input  logic                          r,
    oserdes_burst_gearbox_if.slave        in_if,
    output logic [CHANNELS*SER_WIDTH-1:0] dout,
    output logic                          tout,
    output logic                          busy,
    output logic [15:0]                   bursts
);
    localparam int unsigned W      = SER_WIDTH * RATIO;
    localparam int unsigned DW     = CHANNELS * SER_WIDTH;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned KW     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned PH_MAX = (PRE_LEN > POST_LEN) ? PRE_LEN : POST_LEN;
    localparam int unsigned PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    typedef enum logic [1:0] {StIdle, StPre, StData, StPost} state_e;

    logic [CHANNELS*W-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  in_ready_q;
    logic                  wr_en, pop;

    state_e                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [PW-1:0]         ph_q, ph_d;
    logic [DW-1:0]         dout_q, dout_d;
    logic                  tout_q, busy_q;
    logic [CHANNELS*W-1:0] head;

    assign wr_en           = in_if.in_valid && in_ready_q;
    assign in_if.in_ready  = in_ready_q;
    assign count_d         = count_q + CW'(wr_en) - CW'(pop);
    assign rd_ptr_d        = rd_ptr_q + AW'(pop);

    // The FSM looks only at count_q, so a word written this cycle is seen next cycle.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ph_d    = ph_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = (PRE_LEN == 0) ? StData : StPre;
                    k_d     = '0;
                    ph_d    = '0;
                end
            end
            StPre: begin
                if (ph_q == PW'(PRE_LEN - 1)) begin
                    state_d = StData;
                    k_d     = '0;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            StData: begin
                if (k_q == KW'(RATIO - 1)) begin
                    pop  = 1'b1;
                    k_d  = '0;
                    ph_d = '0;
                    // More than the head left means the next word follows with no gap.
                    if (count_q > CW'(1)) begin
                        state_d = StData;
                    end else begin
                        state_d = (POST_LEN == 0) ? StIdle : StPost;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StPost: begin
                if (ph_q == PW'(POST_LEN - 1)) begin
                    ph_d = '0;
                    k_d  = '0;
                    if (count_q != '0) begin
                        state_d = (PRE_LEN == 0) ? StData : StPre;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with state_q.
    assign head = mem_q[rd_ptr_d];

    always_comb begin
        dout_d = {DW{IDLE_VAL}};
        if (state_d == StData) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                dout_d[ch*SER_WIDTH +: SER_WIDTH] =
                    head[ch*W + 32'(k_d)*SER_WIDTH +: SER_WIDTH];
            end
        end
    end

    always_ff @(posedge c) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_if.in_data;
        end
    end

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StIdle;
            k_q        <= '0;
            ph_q       <= '0;
            dout_q     <= {DW{IDLE_VAL}};
            tout_q     <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + AW'(wr_en);
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= (count_d != CW'(DEPTH));
            state_q    <= state_d;
            k_q        <= k_d;
            ph_q       <= ph_d;
            dout_q     <= dout_d;
            tout_q     <= (state_d == StIdle);
            busy_q     <= (state_d != StIdle);
        end
    end

    assign dout = dout_q;
    assign tout = tout_q;
    assign busy = busy_q;

`ifdef OSERDES_BURST_GEARBOX_STATS_EN
    logic        burst_start;
    logic [15:0] bursts_q;

    // A burst starts on entering PRE, or on entering DATA straight from IDLE/POST.
    assign burst_start = (state_d == StPre && state_q != StPre) ||
                         (state_d == StData && (state_q == StIdle || state_q == StPost));

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            bursts_q <= '0;
        end else if (burst_start) begin
            bursts_q <= bursts_q + 16'd1;
        end
    end

    assign bursts = bursts_q;
`else
    assign bursts = '0;
`endif

endmodule
